// File: rtl/sca_trigger_gen_pkg.sv
// Shared types and constants for the SCA capture-trigger generator.
//   trig_mode_e  : trigger drive mode selected by mode_i
//   trig_state_e : pulse/one-shot sequencer states
//   TrigCntW     : width of the trigger event counter
package sca_trigger_gen_pkg;

    typedef enum logic [1:0] {
        MODE_GATED   = 2'd0,
        MODE_PULSE   = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_OFF     = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } trig_state_e;

    localparam int TrigCntW = 8;

endpackage

// File: rtl/sca_trigger_cnt.sv
// Saturating event counter for trigger rising edges.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   inc_i   : one-cycle increment request
//   count_o : event count, sticks at all-ones
module sca_trigger_cnt
    import sca_trigger_gen_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    output logic [TrigCntW-1:0] count_o
);

    function automatic logic [TrigCntW-1:0] sat_inc(input logic [TrigCntW-1:0] v);
        return (v == {TrigCntW{1'b1}}) ? v : v + TrigCntW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (inc_i) begin
            count_o <= sat_inc(count_o);
        end
    end

endmodule

// File: rtl/sca_trigger_gen.sv
// Side-channel capture-trigger generator. Qualifies the software GPIO trigger
// with the busy status of selected crypto cores and drives the trigger pad as
// a gated level or as a delayed fixed-width pulse (optionally armed one-shot).
// Build option: SCA_TRIGGER_GEN_CNT_EN builds the trigger event counter;
// without it count_o is tied to 0.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   sw_trigger_i         : software trigger from GPIO
//   src_busy_i/src_sel_i : per-source busy flags and enable mask
//   mode_i               : 0 GATED, 1 PULSE, 2 ONESHOT, 3 OFF
//   delay_i, width_i     : pulse delay and width in cycles (width 0 acts as 1)
//   arm_i                : one-shot arm request
//   trigger_o            : registered trigger to the pad
//   armed_o              : one-shot armed flag
//   busy_o               : sequencer in DELAY or ACTIVE
//   count_o              : saturating count of trigger rising edges
module sca_trigger_gen
    import sca_trigger_gen_pkg::*;
#(
    parameter int NumSources = 4,
    parameter int CntW       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sw_trigger_i,
    input  logic [NumSources-1:0] src_busy_i,
    input  logic [NumSources-1:0] src_sel_i,
    input  logic [1:0]            mode_i,
    input  logic [CntW-1:0]       delay_i,
    input  logic [CntW-1:0]       width_i,
    input  logic                  arm_i,
    output logic                  trigger_o,
    output logic                  armed_o,
    output logic                  busy_o,
    output logic [7:0]            count_o
);

    trig_mode_e  mode, mode_q;
    trig_state_e state, state_d;
    logic        q_p0, q_p1, rise_p0;
    logic        fire, abort, trig_d, busy_d, armed_d;
    logic [CntW-1:0] dcnt, dcnt_d, wcnt, wcnt_d, wload;

    // Stage p0: qualification, edge detect, sequencer next state
    always_comb begin
        mode    = trig_mode_e'(mode_i);
        q_p0    = sw_trigger_i & (|(src_busy_i & src_sel_i));
        rise_p0 = q_p0 & ~q_p1;
        wload   = (width_i == '0) ? '0 : width_i - CntW'(1);
        // A mode change mid-operation abandons the pulse immediately.
        abort   = (state != ST_IDLE) && (mode != mode_q);
        fire    = (state == ST_IDLE) && rise_p0 &&
                  ((mode == MODE_PULSE) || ((mode == MODE_ONESHOT) && armed_o));

        state_d = state;
        dcnt_d  = dcnt;
        wcnt_d  = wcnt;
        case (state)
            ST_IDLE: begin
                if (fire) begin
                    // Both lengths are captured here so later input changes
                    // cannot stretch an operation already in flight.
                    wcnt_d = wload;
                    if (delay_i != '0) begin
                        state_d = ST_DELAY;
                        dcnt_d  = delay_i - CntW'(1);
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_DELAY: begin
                if (dcnt == '0) state_d = ST_ACTIVE;
                else            dcnt_d  = dcnt - CntW'(1);
            end
            ST_ACTIVE: begin
                if (wcnt == '0) state_d = ST_IDLE;
                else            wcnt_d  = wcnt - CntW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;

        case (mode)
            MODE_GATED:   trig_d = q_p0;
            MODE_PULSE,
            MODE_ONESHOT: trig_d = (state == ST_ACTIVE) && !abort;
            default:      trig_d = 1'b0;
        endcase
        busy_d  = (state != ST_IDLE) && !abort;
        // Set wins over the clear caused by a one-shot fire.
        armed_d = arm_i | (armed_o & ~(fire && (mode == MODE_ONESHOT)));
    end

    // Stage p1: registered control and outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_OFF;
            q_p1      <= 1'b0;
            trigger_o <= 1'b0;
            busy_o    <= 1'b0;
            armed_o   <= 1'b0;
        end else begin
            state     <= state_d;
            mode_q    <= mode;
            q_p1      <= q_p0;
            trigger_o <= trig_d;
            busy_o    <= busy_d;
            armed_o   <= armed_d;
        end
    end

    always_ff @(posedge clk_i) begin
        dcnt <= dcnt_d;
        wcnt <= wcnt_d;
    end

`ifdef SCA_TRIGGER_GEN_CNT_EN
    logic cnt_inc;
    assign cnt_inc = trig_d & ~trigger_o;

    sca_trigger_cnt u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (cnt_inc),
        .count_o (count_o)
    );
`else
    assign count_o = '0;
`endif

endmodule

// File: tb/tb_sca_trigger_gen.sv
module tb_sca_trigger_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw;
    logic [3:0]  busy, sel;
    logic [1:0]  mode;
    logic [15:0] dly, wid;
    logic        arm;
    logic        trig, armed, bsy;
    logic [7:0]  cnt;

    always #5 clk = ~clk;

    sca_trigger_gen #(.NumSources(4), .CntW(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sw_trigger_i (sw),
        .src_busy_i   (busy),
        .src_sel_i    (sel),
        .mode_i       (mode),
        .delay_i      (dly),
        .width_i      (wid),
        .arm_i        (arm),
        .trigger_o    (trig),
        .armed_o      (armed),
        .busy_o       (bsy),
        .count_o      (cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each fire opens a window of edge numbers during which
    // busy/trigger are expected high; a mode change truncates it.
    int   edge_n;
    bit   m_qp;
    int   m_bstart, m_tstart, m_oend, m_lend;
    bit [1:0] m_mprev;
    bit   m_armed, m_tprev;
    int   m_cnt;

    task automatic model_reset();
        m_qp = 0; m_bstart = 0; m_tstart = 0; m_oend = -1; m_lend = -1;
        m_mprev = 2'd3; m_armed = 0; m_tprev = 0; m_cnt = 0;
    endtask

    function automatic int exp_count();
`ifdef SCA_TRIGGER_GEN_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        bit q, e, in_op, fire, et, eb;
        int wp;
        @(posedge clk);
        edge_n++;
        q     = sw & (|(busy & sel));
        e     = q & ~m_qp;
        in_op = (edge_n <= m_lend);
        if (in_op && (mode != m_mprev)) begin
            m_lend = edge_n;
            m_oend = edge_n - 1;
        end
        fire = !in_op && e && ((mode == 2'd1) || ((mode == 2'd2) && m_armed));
        if (fire) begin
            wp       = (wid == 0) ? 1 : int'(wid);
            m_bstart = edge_n + 1;
            m_tstart = edge_n + int'(dly) + 1;
            m_oend   = edge_n + int'(dly) + wp;
            m_lend   = m_oend;
        end
        eb = (edge_n >= m_bstart) && (edge_n <= m_oend);
        case (mode)
            2'd0:    et = q;
            2'd3:    et = 0;
            default: et = (edge_n >= m_tstart) && (edge_n <= m_oend);
        endcase
        m_armed = arm | (m_armed & ~(fire && (mode == 2'd2)));
        if (et && !m_tprev && m_cnt < 255) m_cnt++;
        m_tprev = et;
        m_qp    = q;
        m_mprev = mode;
        #1;
        check_eq("trigger", int'(trig), int'(et));
        check_eq("busy", int'(bsy), int'(eb));
        check_eq("armed", int'(armed), int'(m_armed));
        check_eq("count", int'(cnt), exp_count());
    endtask

    task automatic drv(input logic s, input logic [1:0] m, input int d, input int w, input logic a);
        sw = s; mode = m; dly = 16'(d); wid = 16'(w); arm = a;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_trigger"}, int'(trig), 0);
        check_eq({tag, "_busy"}, int'(bsy), 0);
        check_eq({tag, "_armed"}, int'(armed), 0);
        check_eq({tag, "_count"}, int'(cnt), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        busy = '0; sel = '0;
        drv(0, 2'd3, 0, 0, 0);
        edge_n = 0;
        model_reset();
        #2;
        check_eq("reset_trigger", int'(trig), 0);
        check_eq("reset_busy", int'(bsy), 0);
        check_eq("reset_armed", int'(armed), 0);
        check_eq("reset_count", int'(cnt), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // GATED with source 0 selected and busy, then not busy
        sel = 4'b0001; busy = 4'b0001;
        drv(0, 2'd0, 0, 0, 0); run(2);
        drv(1, 2'd0, 0, 0, 0); run(5);
        drv(0, 2'd0, 0, 0, 0); run(3);
        busy = 4'b0000;
        drv(1, 2'd0, 0, 0, 0); run(5);
        drv(0, 2'd0, 0, 0, 0); run(2);
        busy = 4'b0001;

        // PULSE D=3 W=4, q held high afterwards (no retrigger)
        drv(0, 2'd1, 3, 4, 0); run(3);
        drv(1, 2'd1, 3, 4, 0); run(12);
        drv(0, 2'd1, 3, 4, 0); run(2);

        // PULSE D=0 W=0, then a second edge during ACTIVE is ignored
        drv(1, 2'd1, 0, 0, 0); run(1);
        drv(0, 2'd1, 0, 0, 0); run(2);
        drv(1, 2'd1, 0, 3, 0); run(1);
        drv(0, 2'd1, 5, 10, 0); run(1);
        drv(1, 2'd1, 5, 10, 0); run(1);
        drv(0, 2'd1, 5, 10, 0); run(20);

        // ONESHOT: no arm, then armed, then arm coincident with fire
        drv(0, 2'd2, 1, 2, 0); run(2);
        for (int i = 0; i < 2; i++) begin
            drv(1, 2'd2, 1, 2, 0); run(1);
            drv(0, 2'd2, 1, 2, 0); run(5);
        end
        drv(0, 2'd2, 1, 2, 1); run(1);
        for (int i = 0; i < 2; i++) begin
            drv(1, 2'd2, 1, 2, 0); run(1);
            drv(0, 2'd2, 1, 2, 0); run(5);
        end
        drv(0, 2'd2, 0, 1, 1); run(1);
        drv(1, 2'd2, 0, 1, 1); run(1);
        drv(0, 2'd2, 0, 1, 0); run(4);

        // Mode change PULSE -> OFF during DELAY
        drv(0, 2'd1, 4, 2, 0); run(1);
        drv(1, 2'd1, 4, 2, 0); run(2);
        drv(1, 2'd3, 4, 2, 0); run(8);

        // Reset during ACTIVE
        drv(0, 2'd1, 0, 8, 0); run(1);
        drv(1, 2'd1, 0, 8, 0); run(3);
        async_reset("rst_active");
        drv(0, 2'd1, 0, 0, 0); run(2);

        // Counter saturation with 300 single-cycle pulses
        for (int i = 0; i < 300; i++) begin
            drv(1, 2'd1, 0, 0, 0); run(1);
            drv(0, 2'd1, 0, 0, 0); run(1);
        end
`ifdef SCA_TRIGGER_GEN_CNT_EN
        check_eq("count_sat", int'(cnt), 255);
`else
        check_eq("count_sat", int'(cnt), 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
            sw   = 1'($urandom_range(1));
            busy = 4'($urandom);
            if ($urandom_range(19) == 0) sel = 4'($urandom);
            dly  = 16'($urandom_range(5));
            wid  = 16'($urandom_range(5));
            arm  = ($urandom_range(7) == 0);
            if ($urandom_range(599) == 0) async_reset("rst_rand");
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sca_trigger_gen.md
# sca_trigger_gen

Parametrised side-channel capture-trigger generator for FPGA targets (CW305-class boards). It qualifies a software-driven GPIO trigger with the busy status of a selectable set of crypto cores (AES, KMAC, OTBN, …). It then drives the capture-trigger pad either as a gated level or as a delayed, fixed-width pulse, optionally armed one-shot. It sits between the core's MIO output and the padring, on the trigger pad only.

## Interface
- `NumSources`, 4: number of busy-source inputs.
- `CntW`, 16: width of the delay and width counters.
- `clk_i` in 1: trigger clock, the core main clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `sw_trigger_i` in 1: software trigger from the core GPIO (MIO) output.
- `src_busy_i` in NumSources: per-source busy, active high (equal to ~idle).
- `src_sel_i` in NumSources: source enable mask.
- `mode_i` in 2: 0 GATED, 1 PULSE, 2 ONESHOT, 3 OFF.
- `delay_i` in CntW: cycles between the qualified edge and trigger assertion.
- `width_i` in CntW: pulse width in cycles; 0 is treated as 1.
- `arm_i` in 1: single-cycle arm request, used in ONESHOT mode.
- `trigger_o` out 1: registered trigger to the pad.
- `armed_o` out 1: one-shot armed flag.
- `busy_o` out 1: FSM is in DELAY or ACTIVE.
- `count_o` out 8: saturating count of trigger rising edges.

## Operation
- Qualified signal: `q = sw_trigger_i & |(src_busy_i & src_sel_i)`. It is registered to `q_q`. Edge: `e = q & ~q_q`.
- GATED: `trigger_o <= q`. The FSM stays in IDLE.
- OFF (mode 3): `trigger_o` is held 0 and the FSM is held in IDLE.
- PULSE and ONESHOT share one FSM with states IDLE, DELAY, ACTIVE:
  - IDLE → DELAY on a fire condition when `delay_i != 0`. `dcnt` is loaded with `delay_i-1`.
  - IDLE → ACTIVE on a fire condition when `delay_i == 0`. `wcnt` is loaded with `max(width_i,1)-1`.
  - DELAY: `dcnt` decrements each cycle. When `dcnt == 0`, go to ACTIVE and load `wcnt`.
  - ACTIVE: `trigger_o` is 1 and `wcnt` decrements. When `wcnt == 0`, go to IDLE.
- Fire condition: PULSE fires on `e`. ONESHOT fires on `e & armed`.
- `delay_i` and `width_i` are sampled only at load time. Later changes do not affect an operation already in progress.
- Edges arriving during DELAY or ACTIVE are ignored. There is no queueing.
- If `q` stays high, no retrigger occurs. A new trigger requires a low-to-high transition of `q`.
- `armed` is set by `arm_i` and cleared when the FSM leaves IDLE in ONESHOT mode. If `arm_i` and the clear occur in the same cycle, the set wins and `armed` stays 1.
- A change of `mode_i` while in DELAY or ACTIVE forces the FSM to IDLE on the next edge, and `trigger_o` goes to 0.
- `count_o` increments on every 0→1 transition of `trigger_o`, in all modes. It saturates at 255.

## Timing
- Reset values: `trigger_o`=0, `armed_o`=0, `busy_o`=0, `count_o`=0. FSM is in IDLE, `q_q`=0.
- GATED latency: `trigger_o` follows `q` with 1 cycle of latency.
- PULSE latency: if `e` is true at clock edge k, `trigger_o` is high from edge k+1+D through edge k+D+max(W,1).
  - D = `delay_i`, W = `width_i`.
  - Total high time is exactly max(W,1) cycles.
- Back-to-back pulses: the earliest next fire is the cycle after ACTIVE ends. The minimum low gap is 1 cycle, because the edge must be re-detected.
- `busy_o` is registered and is high exactly in the DELAY and ACTIVE states.
- Reset asserted mid-operation: all outputs clear asynchronously.

## Configuration
- `SCA_TRIGGER_GEN_CNT_EN`:
  - Defined: the 8-bit saturating event counter is built and drives `count_o`.
  - Undefined: the counter is not instantiated and `count_o` is tied to 0.

## Structure
- The shared package `sca_trigger_gen_pkg` holds:
  - `trig_mode_e` (GATED, PULSE, ONESHOT, OFF).
  - `trig_state_e` (IDLE, DELAY, ACTIVE).
  - `TrigCntW = 8` (event-counter width).
- One sub-module, `sca_trigger_cnt`, implements the saturating event counter. It is instantiated only under the macro.
- The FSM, the delay/width counters and the edge detect live in the top module.

## Test plan
- GATED, sel=4'b0001, busy[0]=1, sw toggled high for 5 cycles → `trigger_o` is high for 5 cycles, lagging `sw` by 1 cycle. With busy[0]=0, `trigger_o` stays 0.
- PULSE, D=3, W=4, `e` at edge 10 → `trigger_o` is high at edges 14–17, `busy_o` is high at edges 11–17, `count_o`=1.
- PULSE, D=0, W=0 → a 1-cycle pulse at edge k+1. A second `e` during ACTIVE with D=5, W=10 is ignored.
- ONESHOT: two edges with no arm → no trigger. Pulse `arm_i`, then two edges → exactly one pulse. `armed_o` drops on fire. `arm_i` coincident with the fire → `armed_o` stays 1.
- Mode change PULSE→OFF during DELAY, and `rst_ni` pulsed during ACTIVE → `trigger_o`=0 next cycle (for reset: immediately). All outputs return to reset values.
- 300 PULSE triggers with the macro defined → `count_o`=255. With the macro undefined → `count_o`=0.
